// File: rtl/note_seq_pkg.sv
// note_seq_pkg
// Shared definitions for the note sequencer and anything that builds or
// decodes song ROM images: note word layout, field widths, state encoding
// and a small unpack helper.
//   Word layout: [15:10] pitch, [9:5] duration, [4:1] instrument, [0] end flag.
package note_seq_pkg;

    localparam int WORD_W   = 16;
    localparam int PITCH_W  = 6;
    localparam int DUR_W    = 5;
    localparam int INSTR_W  = 4;
    localparam int END_BIT  = 0;
    // duration+1 can reach 32, so one bit wider than the duration field
    localparam int FRAMES_W = DUR_W + 1;

    // Field order matches the ROM bit layout MSB to LSB, so a plain cast unpacks.
    typedef struct packed {
        logic [PITCH_W-1:0] pitch;
        logic [DUR_W-1:0]   duration;
        logic [INSTR_W-1:0] instrument;
        logic               end_flag;
    } note_word_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_PLAY    = 3'd3,
        ST_DRAIN   = 3'd4
    } seq_state_t;

    function automatic note_word_t unpack_note(input logic [WORD_W-1:0] word);
        return note_word_t'(word);
    endfunction

endpackage

// File: rtl/note_sequencer.sv
// note_sequencer
// Walks a song ROM of packed note words and presents pitch / duration /
// instrument to the note player on registered outputs. Each note is held for
// duration+1 frame strobes; the following word is prefetched while the current
// note plays so it can be committed on the very strobe that ends the note.
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_frame_stb       one-cycle frame tick shared with the player
//   i_start / i_stop  start from SONG_BASE when idle / abort playback
//   o_load            one-cycle pulse after new note fields are committed
//   o_pitch, o_duration, o_instrument   current note fields
//   o_busy            high whenever not idle
//   o_rom_addr        song ROM address (non-zero only while fetching)
//   i_rom_data        song ROM data, one cycle after the address
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int SONG_BASE  = 0,
    parameter int LOOP_ADDR  = 0,
    parameter int LOOP       = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_frame_stb,
    input  logic                  i_start,
    input  logic                  i_stop,
    output logic                  o_load,
    output logic [PITCH_W-1:0]    o_pitch,
    output logic [DUR_W-1:0]      o_duration,
    output logic [INSTR_W-1:0]    o_instrument,
    output logic                  o_busy,
    output logic [ADDR_WIDTH-1:0] o_rom_addr,
    input  logic [WORD_W-1:0]     i_rom_data
);

    localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(SONG_BASE);
    localparam logic [ADDR_WIDTH-1:0] LOOP_A = ADDR_WIDTH'(LOOP_ADDR);

    seq_state_t            state_reg, state_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [WORD_W-1:0]     next_word_reg, next_word_next;
    logic                  next_valid_reg, next_valid_next;
    logic [FRAMES_W-1:0]   frames_left_reg, frames_left_next;
    logic                  end_seen_reg, end_seen_next;
    logic [PITCH_W-1:0]    pitch_reg, pitch_next;
    logic [DUR_W-1:0]      duration_reg, duration_next;
    logic [INSTR_W-1:0]    instrument_reg, instrument_next;
    logic                  load_reg, load_next;

    note_word_t rom_word;
    note_word_t commit_word;
    logic       commit;
    logic       frame_done;

    assign rom_word = unpack_note(i_rom_data);

    // The current note is over either already (counter at 0) or at this edge
    // (last remaining frame being consumed by a strobe right now).
    assign frame_done = (frames_left_reg == '0) ||
                        (i_frame_stb && frames_left_reg == FRAMES_W'(1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg       <= ST_IDLE;
            addr_reg        <= '0;
            next_word_reg   <= '0;
            next_valid_reg  <= 1'b0;
            frames_left_reg <= '0;
            end_seen_reg    <= 1'b0;
            pitch_reg       <= '0;
            duration_reg    <= '0;
            instrument_reg  <= '0;
            load_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            addr_reg        <= addr_next;
            next_word_reg   <= next_word_next;
            next_valid_reg  <= next_valid_next;
            frames_left_reg <= frames_left_next;
            end_seen_reg    <= end_seen_next;
            pitch_reg       <= pitch_next;
            duration_reg    <= duration_next;
            instrument_reg  <= instrument_next;
            load_reg        <= load_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        addr_next        = addr_reg;
        next_word_next   = next_word_reg;
        next_valid_next  = next_valid_reg;
        frames_left_next = frames_left_reg;
        end_seen_next    = end_seen_reg;
        pitch_next       = pitch_reg;
        duration_next    = duration_reg;
        instrument_next  = instrument_reg;
        load_next        = 1'b0;
        commit           = 1'b0;
        commit_word      = unpack_note(next_word_reg);

        // Strobes are counted in every active state, including FETCH/CAPTURE.
        if (state_reg != ST_IDLE && i_frame_stb && frames_left_reg != '0) begin
            frames_left_next = frames_left_reg - FRAMES_W'(1);
        end

        if (i_stop) begin
            state_next       = ST_IDLE;
            next_valid_next  = 1'b0;
            frames_left_next = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (i_start) begin
                        addr_next        = BASE_A;
                        frames_left_next = '0;
                        state_next       = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state_next = ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    next_word_next  = i_rom_data;
                    next_valid_next = 1'b1;
                    addr_next       = rom_word.end_flag ? LOOP_A : addr_reg + 1'b1;
                    if (frame_done) begin
                        // First note or late prefetch: commit straight from
                        // the ROM bus rather than waiting a cycle.
                        commit      = 1'b1;
                        commit_word = rom_word;
                    end else begin
                        state_next = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (frame_done && next_valid_reg) begin
                        commit = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (frame_done && end_seen_reg) begin
                        state_next = ST_IDLE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end

        if (commit) begin
            pitch_next       = commit_word.pitch;
            duration_next    = commit_word.duration;
            instrument_next  = commit_word.instrument;
            frames_left_next = {1'b0, commit_word.duration} + FRAMES_W'(1);
            end_seen_next    = commit_word.end_flag;
            next_valid_next  = 1'b0;
            load_next        = 1'b1;
            state_next       = (LOOP == 0 && commit_word.end_flag) ? ST_DRAIN : ST_FETCH;
        end
    end

    assign o_load       = load_reg;
    assign o_pitch      = pitch_reg;
    assign o_duration   = duration_reg;
    assign o_instrument = instrument_reg;
    assign o_busy       = (state_reg != ST_IDLE);
    assign o_rom_addr   = (state_reg == ST_FETCH) ? addr_reg : '0;

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Upstream feeder for the note player. Walks a song ROM of packed 16-bit note words and presents pitch, duration and instrument on registered outputs.
- Holds each note for exactly the number of frame strobes the player consumes, which is duration+1.
- Prefetches the next word during the current note, so the next note is on the outputs before the player returns to idle.
- Loops or stops at an end-of-pattern marker.

Parameters:
- ADDR_WIDTH, 8: song ROM address width.
- SONG_BASE, 0: address of the first note word.
- LOOP_ADDR, 0: address fetched after a word with the end flag set, when LOOP=1.
- LOOP, 1: 1 = wrap to LOOP_ADDR after the end word; 0 = stop after the end note finishes.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset
- i_frame_stb  in  1  one-cycle frame tick, shared with the note player
- i_start  in  1  pulse; starts playback from SONG_BASE when idle
- i_stop  in  1  pulse; aborts playback
- o_load  out  1  one-cycle pulse, high in the cycle after new note fields are committed
- o_pitch  out  6  note pitch index
- o_duration  out  5  extra frames after the first frame
- o_instrument  out  4  instrument index
- o_busy  out  1  high from start until idle
- o_rom_addr  out  ADDR_WIDTH  song ROM address
- i_rom_data  in  16  song ROM data; synchronous ROM, one-cycle latency

Behaviour:
- Interface: one clock, i_clk. i_rst is asynchronous, active-high. All outputs are 0 in reset and registers clear immediately on assertion.
- Word format:
  - [15:10] pitch
  - [9:5] duration
  - [4:1] instrument
  - [0] end flag
- Registers:
  - addr (ADDR_WIDTH)
  - next_word (16) with next_valid
  - frames_left (6 bits, holds up to 32)
  - end_seen
- Frame counting: in any non-IDLE state, i_frame_stb decrements frames_left, saturating at 0.
- Commit action, all at one clock edge:
  - o_pitch/o_duration/o_instrument <= fields of next_word
  - frames_left <= duration+1
  - end_seen <= end flag
  - next_valid <= 0
  - o_load <= 1 for one cycle
- States:
  - IDLE: o_busy=0, o_rom_addr=0. On i_start (and not i_stop): addr <= SONG_BASE, frames_left <= 0, go FETCH.
  - FETCH: o_rom_addr=addr; go CAPTURE.
  - CAPTURE:
    - next_word <= i_rom_data, next_valid <= 1.
    - addr <= (end flag ? LOOP_ADDR : addr+1), wrapping modulo 2^ADDR_WIDTH.
    - If frames_left==0 (first note, or late prefetch): commit immediately, go FETCH (or DRAIN, see below).
    - Otherwise go PLAY.
  - PLAY: when i_frame_stb is high and frames_left==1, commit at that edge and go FETCH. The player samples the old fields at that edge, because it reads inputs only when leaving IDLE/PLAYING.
  - DRAIN: entered instead of FETCH when LOOP=0 and end_seen=1 after a commit. No further fetch. When frames_left reaches 0, go IDLE and drop o_busy.
- o_busy=1 in all states except IDLE.
- o_rom_addr is combinational: addr in FETCH, else 0.
- Outputs hold their last value in IDLE.
- Boundaries:
  - i_stop in any state: go IDLE next edge, clear next_valid and frames_left, no o_load. i_stop wins over i_start in the same cycle.
  - i_start while busy: ignored.
  - Strobe during FETCH/CAPTURE: still counted. If it empties frames_left, CAPTURE commits late, with no lost note.
  - Strobe spacing must be at least 4 cycles.
  - duration=31 gives 32 frames; frames_left is 6-bit so it cannot overflow.
  - addr at all-ones with no end flag wraps to 0.
  - Reset mid-note: all registers clear asynchronously; outputs read 0.

Decomposition:
- Shared package (e.g. apu_pkg):
  - note word field positions and widths (PITCH_W=6, DUR_W=5, INSTR_W=4, END_BIT=0)
  - state encodings
- No sub-module needed. Optionally extract note_word_unpack as a combinational helper used by this block and the song assembler test model.

Test Plan:
- ROM[0]=pitch 5, dur 2, instr 3, end 0; ROM[1]=pitch 7, dur 0, instr 1, end 1; LOOP=1. Pulse i_start -> o_load 3 cycles later with o_pitch=5, o_duration=2, o_instrument=3. The next fields (7,0,1) commit exactly at the 3rd strobe edge. The note after that is ROM[0] again, committed at the following strobe.
- Same ROM with LOOP=0 -> after note (7,0,1) has had its one frame, o_busy falls. Only 2 o_load pulses in total.
- duration=31 note -> 32 strobes between consecutive o_load pulses.
- Strobe injected the cycle after commit with frames_left=1 (duration 0) -> the late commit happens in CAPTURE and no note is skipped.
- i_stop during PLAY -> IDLE next edge, o_busy=0, no o_load. A following i_start restarts at SONG_BASE.
- i_rst asserted asynchronously mid-PLAY -> all outputs 0 before the next clock edge. After release, stays IDLE until i_start.
